// File: rtl/touch_swipe_detector.sv
// Swipe recognizer for a capacitive touch panel: follows a single-finger track and
// reports one compass direction when the finger lifts or goes quiet.
module touch_swipe_detector #(
    parameter int THRESH_X    = 100,
    parameter int THRESH_Y    = 60,
    parameter int RELEASE_GAP = 2_500_000,
    parameter int MAX_TRACK   = 50_000_000,
    parameter int HOLDOFF     = 12_500_000
) (
    input  logic       iCLK,
    input  logic       iRSTN,
    input  logic       touch_ready,
    input  logic [1:0] reg_touch_count,
    input  logic [9:0] reg_x1,
    input  logic [8:0] reg_y1,
    output logic       gest_n,
    output logic       gest_e,
    output logic       gest_s,
    output logic       gest_w,
    output logic       gest_valid,
    output logic [1:0] gest_dir,
    output logic       busy
);

    localparam int GAP_W = $clog2(RELEASE_GAP + 1);
    localparam int TRK_W = $clog2(MAX_TRACK + 1);
    localparam int HLD_W = $clog2(HOLDOFF + 1);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RELEASE_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(RELEASE_GAP);
    localparam logic [TRK_W-1:0] TRK_LAST = TRK_W'(MAX_TRACK - 1);
    localparam logic [TRK_W-1:0] TRK_MAX  = TRK_W'(MAX_TRACK);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF - 1);
    localparam logic [HLD_W-1:0] HLD_MAX  = HLD_W'(HOLDOFF);

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_EVAL  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [9:0]       start_x;
    logic [8:0]       start_y;
    logic [9:0]       last_x;
    logic [8:0]       last_y;
    logic [GAP_W-1:0] gap_cnt;
    logic [TRK_W-1:0] track_cnt;
    logic [HLD_W-1:0] hold_cnt;

    logic signed [10:0] dx;
    logic signed [9:0]  dy;
    logic [10:0]        abs_dx;
    logic [9:0]         abs_dy;
    logic               hit;
    logic [1:0]         dir_next;

    logic sample_one;
    logic sample_zero;
    logic sample_multi;

    assign sample_one   = touch_ready && (reg_touch_count == 2'd1);
    assign sample_zero  = touch_ready && (reg_touch_count == 2'd0);
    assign sample_multi = touch_ready && reg_touch_count[1];

    // Zero-extend before subtracting so the full screen span never overflows.
    assign dx = $signed({1'b0, last_x}) - $signed({1'b0, start_x});
    assign dy = $signed({1'b0, last_y}) - $signed({1'b0, start_y});

    always_comb begin
        abs_dx   = dx[10] ? 11'(-dx) : 11'(dx);
        abs_dy   = dy[9]  ? 10'(-dy) : 10'(dy);
        hit      = 1'b0;
        dir_next = gest_dir;
        // Horizontal wins ties; Y grows downward so positive dy is south.
        if ((abs_dx >= {1'b0, abs_dy}) && (int'(abs_dx) >= THRESH_X)) begin
            hit      = 1'b1;
            dir_next = dx[10] ? DIR_W : DIR_E;
        end else if (int'(abs_dy) >= THRESH_Y) begin
            hit      = 1'b1;
            dir_next = dy[9] ? DIR_N : DIR_S;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            state      <= S_IDLE;
            start_x    <= '0;
            start_y    <= '0;
            last_x     <= '0;
            last_y     <= '0;
            gap_cnt    <= '0;
            track_cnt  <= '0;
            hold_cnt   <= '0;
            gest_n     <= 1'b0;
            gest_e     <= 1'b0;
            gest_s     <= 1'b0;
            gest_w     <= 1'b0;
            gest_valid <= 1'b0;
            gest_dir   <= DIR_N;
            busy       <= 1'b0;
        end else begin
            gest_n     <= 1'b0;
            gest_e     <= 1'b0;
            gest_s     <= 1'b0;
            gest_w     <= 1'b0;
            gest_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (sample_one) begin
                        start_x   <= reg_x1;
                        start_y   <= reg_y1;
                        last_x    <= reg_x1;
                        last_y    <= reg_y1;
                        gap_cnt   <= '0;
                        track_cnt <= '0;
                        state     <= S_TRACK;
                        busy      <= 1'b1;
                    end
                end

                S_TRACK: begin
                    if (sample_one) begin
                        last_x  <= reg_x1;
                        last_y  <= reg_y1;
                        gap_cnt <= '0;
                    end else if (!touch_ready && (gap_cnt != GAP_MAX)) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                    if (track_cnt != TRK_MAX) begin
                        track_cnt <= track_cnt + 1'b1;
                    end

                    // Release beats the track timeout when both land together.
                    if (sample_zero) begin
                        state <= S_EVAL;
                    end else if (sample_multi) begin
                        hold_cnt <= '0;
                        state    <= S_HOLD;
                    end else if (!touch_ready && (gap_cnt == GAP_LAST)) begin
                        state <= S_EVAL;
                    end else if (track_cnt == TRK_LAST) begin
                        hold_cnt <= '0;
                        state    <= S_HOLD;
                    end
                end

                S_EVAL: begin
                    if (hit) begin
                        gest_valid <= 1'b1;
                        gest_dir   <= dir_next;
                        gest_n     <= (dir_next == DIR_N);
                        gest_e     <= (dir_next == DIR_E);
                        gest_s     <= (dir_next == DIR_S);
                        gest_w     <= (dir_next == DIR_W);
                    end
                    hold_cnt <= '0;
                    state    <= S_HOLD;
                end

                S_HOLD: begin
                    if (hold_cnt == HLD_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (hold_cnt != HLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_swipe_detector.sv
// Bench for touch_swipe_detector: a timestamp-based reference model checked every
// cycle, directed swipe scenarios with literal expectations, then random traffic.
module tb_touch_swipe_detector;

    localparam int RG = 16;
    localparam int HO = 32;
    localparam int MT = 1000;
    localparam int TX = 100;
    localparam int TY = 60;

    logic       clk = 1'b0;
    logic       rstn;
    logic       touch_ready;
    logic [1:0] cnt;
    logic [9:0] x;
    logic [8:0] y;
    logic       gn, ge, gs, gw, gv;
    logic [1:0] gdir;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    touch_swipe_detector #(
        .THRESH_X(TX), .THRESH_Y(TY), .RELEASE_GAP(RG), .MAX_TRACK(MT), .HOLDOFF(HO)
    ) dut (
        .iCLK(clk), .iRSTN(rstn), .touch_ready(touch_ready), .reg_touch_count(cnt),
        .reg_x1(x), .reg_y1(y), .gest_n(gn), .gest_e(ge), .gest_s(gs), .gest_w(gw),
        .gest_valid(gv), .gest_dir(gdir), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the attempt with timestamps (edge numbers) rather than counters.
    int         e_idx = 0;
    bit         m_live = 0, m_trk = 0, m_ev = 0;
    int         m_entry = 0, m_last = 0, m_hold_end = 0;
    int         sx = 0, sy = 0, lx = 0, ly = 0, m_dir = 0;
    logic [7:0] m_exp = '0;

    always @(posedge clk) begin : model
        int adx, ady;
        logic [3:0] p;
        e_idx++;
        m_live = 1;
        p = 4'b0000;
        if (!rstn) begin
            m_trk = 0; m_ev = 0; m_hold_end = 0; m_dir = 0;
            sx = 0; sy = 0; lx = 0; ly = 0;
        end else if (m_ev) begin
            adx = lx - sx; if (adx < 0) adx = -adx;
            ady = ly - sy; if (ady < 0) ady = -ady;
            if (adx >= ady && adx >= TX) begin
                m_dir = (lx > sx) ? 1 : 3;
                p = (lx > sx) ? 4'b0100 : 4'b0001;
            end else if (ady >= TY) begin
                m_dir = (ly > sy) ? 2 : 0;
                p = (ly > sy) ? 4'b0010 : 4'b1000;
            end
            m_ev = 0;
            m_hold_end = e_idx + HO + 1;
        end else if (m_trk) begin
            if (touch_ready && cnt == 2'd1) begin
                lx = int'(x); ly = int'(y); m_last = e_idx;
            end
            if (touch_ready && cnt == 2'd0) begin
                m_trk = 0; m_ev = 1;
            end else if (touch_ready && cnt >= 2'd2) begin
                m_trk = 0; m_hold_end = e_idx + HO + 1;
            end else if (!touch_ready && (e_idx - m_last) >= RG) begin
                m_trk = 0; m_ev = 1;
            end else if ((e_idx - m_entry) >= MT) begin
                m_trk = 0; m_hold_end = e_idx + HO + 1;
            end
        end else if (e_idx >= m_hold_end && touch_ready && cnt == 2'd1) begin
            m_trk = 1;
            sx = int'(x); sy = int'(y); lx = sx; ly = sy;
            m_entry = e_idx; m_last = e_idx;
        end
        m_exp = {p, |p, 2'(m_dir), (m_trk || m_ev || (m_hold_end > e_idx + 1))};
    end

    always @(negedge clk) begin
        if (m_live) begin
            checks++;
            if (gv === 1'b1) pulses++;
            if ({gn, ge, gs, gw, gv, gdir, busy} !== m_exp) begin
                errors++;
                $display("[TB] FAIL cycle_cmp edge %0d: got nesw=%b%b%b%b valid=%b dir=%0d busy=%b, expected nesw=%b valid=%b dir=%0d busy=%b",
                         e_idx, gn, ge, gs, gw, gv, gdir, busy,
                         m_exp[7:4], m_exp[3], m_exp[2:1], m_exp[0]);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic [1:0] c, input int px, input int py);
        touch_ready = r;
        cnt         = c;
        x           = 10'(px);
        y           = 9'(py);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            applyStimulus(1'b0, 2'd0, 0, 0);
            n++;
        end
        checkOutput("wait_idle", int'(busy), 0);
    endtask

    task automatic swipe(input int x0, input int y0, input int x1, input int y1);
        applyStimulus(1'b1, 2'd1, x0, y0);
        applyStimulus(1'b1, 2'd1, x1, y1);
        applyStimulus(1'b1, 2'd0, 0, 0);
    endtask

    task automatic resetPulse();
        rstn = 1'b0;
        applyStimulus(1'b0, 2'd0, 0, 0);
        rstn = 1'b1;
    endtask

    initial begin
        int p0;
        rstn = 1'b0; touch_ready = 1'b0; cnt = 2'd0; x = '0; y = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_dir", int'(gdir), 0);
        checkOutput("reset_valid", int'(gv), 0);
        rstn = 1'b1;

        $display("[TB] east swipe with release sample");
        applyStimulus(1'b1, 2'd1, 100, 240);
        applyStimulus(1'b1, 2'd1, 200, 240);
        applyStimulus(1'b1, 2'd1, 300, 240);
        applyStimulus(1'b1, 2'd0, 0, 0);
        checkOutput("e_eval_no_pulse", int'(gv), 0);
        checkOutput("e_busy", int'(busy), 1);
        idle(1);
        checkOutput("e_gest_e", int'(ge), 1);
        checkOutput("e_valid", int'(gv), 1);
        checkOutput("e_dir", int'(gdir), 1);
        idle(1);
        checkOutput("e_pulse_single", int'(gv), 0);
        checkOutput("e_dir_held", int'(gdir), 1);
        waitIdle();

        $display("[TB] short move below thresholds");
        swipe(300, 100, 370, 150);
        idle(1);
        checkOutput("short_no_pulse", int'(gv), 0);
        checkOutput("short_dir_held", int'(gdir), 1);
        waitIdle();

        $display("[TB] north swipe ended by gap expiry");
        applyStimulus(1'b1, 2'd1, 400, 400);
        applyStimulus(1'b1, 2'd1, 410, 300);
        idle(15);
        checkOutput("n_still_tracking", int'(busy), 1);
        idle(1);
        checkOutput("n_eval_no_pulse", int'(gv), 0);
        idle(1);
        checkOutput("n_gest_n", int'(gn), 1);
        checkOutput("n_dir", int'(gdir), 0);
        waitIdle();

        $display("[TB] threshold boundaries");
        swipe(300, 300, 200, 200);
        idle(1);
        checkOutput("tie_gest_w", int'(gw), 1);
        checkOutput("tie_dir", int'(gdir), 3);
        waitIdle();
        swipe(50, 100, 50, 159);
        idle(1);
        checkOutput("dy59_no_pulse", int'(gv), 0);
        waitIdle();
        swipe(50, 100, 50, 160);
        idle(1);
        checkOutput("dy60_gest_s", int'(gs), 1);
        checkOutput("dy60_dir", int'(gdir), 2);
        waitIdle();

        $display("[TB] multi-touch abort and holdoff");
        p0 = pulses;
        applyStimulus(1'b1, 2'd1, 100, 100);
        applyStimulus(1'b1, 2'd2, 0, 0);
        checkOutput("mt_busy", int'(busy), 1);
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 2'd1 : 2'd0, 700, 400);
            checkOutput("mt_hold_busy", int'(busy), 1);
        end
        applyStimulus(1'b1, 2'd1, 10, 10);
        checkOutput("mt_hold_end", int'(busy), 0);
        idle(3);
        checkOutput("mt_sample_ignored", int'(busy), 0);
        checkOutput("mt_no_pulse", pulses - p0, 0);

        $display("[TB] reset during tracking");
        applyStimulus(1'b1, 2'd1, 600, 200);
        applyStimulus(1'b1, 2'd1, 500, 200);
        resetPulse();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_dir", int'(gdir), 0);
        checkOutput("rst_valid", int'(gv), 0);
        p0 = pulses;
        idle(20);
        checkOutput("rst_no_late_pulse", pulses - p0, 0);
        swipe(700, 300, 550, 300);
        idle(1);
        checkOutput("rst_then_w", int'(gw), 1);
        checkOutput("rst_then_w_dir", int'(gdir), 3);
        waitIdle();

        $display("[TB] track timeout");
        p0 = pulses;
        applyStimulus(1'b1, 2'd1, 100, 100);
        for (int i = 1; i <= 1010; i++) begin
            if (i % 10 == 0) applyStimulus(1'b1, 2'd1, 700, 100);
            else applyStimulus(1'b0, 2'd0, 0, 0);
        end
        checkOutput("timeout_in_hold", int'(busy), 1);
        waitIdle();
        checkOutput("timeout_no_pulse", pulses - p0, 0);

        $display("[TB] random traffic");
        for (int a = 0; a < 80; a++) begin
            int n, kind;
            if ($urandom_range(0, 14) == 0) resetPulse();
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                applyStimulus(1'b1, 2'd1, $urandom_range(0, 799), $urandom_range(0, 479));
                idle($urandom_range(0, 17));
            end
            kind = $urandom_range(0, 3);
            case (kind)
                0: applyStimulus(1'b1, 2'd0, 0, 0);
                1: applyStimulus(1'b1, 2'($urandom_range(2, 3)), 0, 0);
                2: idle(18);
                default: applyStimulus(1'b1, 2'($urandom_range(0, 3)),
                                       $urandom_range(0, 799), $urandom_range(0, 479));
            endcase
            for (int k = 0; k < int'($urandom_range(0, 40)); k++) begin
                applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                              $urandom_range(0, 799), $urandom_range(0, 479));
            end
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
